seq_pattern_detector: RTL
=========================

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 The block SHALL have parameter PW, default 8, meaning pattern/window width in bits, legal range 2..16.
REQ-002 The block SHALL have parameter CW, default 16, meaning match-counter width in bits, legal range 4..32.
REQ-003 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches counted, 0 = window restarts after each match.
REQ-004 Clk  input  1  sole clock, all state updates on rising edge.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 En  input  1  Sin valid qualifier; window shifts only on edges with En=1.
REQ-007 Sin  input  1  serial data bit.
REQ-008 Pattern  input  PW  target pattern; Pattern[PW-1] compared against oldest window bit.
REQ-009 Mask  input  PW  per-bit compare enable; 1 = compare, 0 = don't-care.
REQ-010 Clear  input  1  synchronous clear of window, fill state, counter and flags.
REQ-011 Match  output  1  registered one-cycle pulse per detected match.
REQ-012 Pcount  output  CW  registered saturating match count.
REQ-013 Sat  output  1  registered flag, high while Pcount equals 2^CW-1.

Function
REQ-014 The block SHALL hold a PW-bit shift window; on an edge with En=1, window <= {window[PW-2:0], Sin}; with En=0, window holds.
REQ-015 The block SHALL track fill state with a 2-state FSM: FILL (fewer than PW valid bits since last reset/Clear/restart) and ARMED (window holds PW valid bits).
REQ-016 FILL SHALL count accepted bits with a counter of width clog2(PW+1); the edge accepting the PW-th bit SHALL transition to ARMED.
REQ-017 A match SHALL be evaluated only on an edge with En=1, using the post-shift window {window[PW-2:0], Sin}, and only when that post-shift window holds PW valid bits (ARMED, or the FILL edge accepting the PW-th bit).
REQ-018 Match condition SHALL be ((post-shift window XOR Pattern) AND Mask) == 0, using Pattern and Mask sampled on that same edge.
REQ-019 Mask = all zeros SHALL match on every qualifying edge.
REQ-020 On a match edge, Match SHALL be 1 for exactly the following cycle; on all other edges Match SHALL be 0, so latency = 1 clock from the edge that samples the last pattern bit.
REQ-021 On a match edge, Pcount SHALL increment by 1 unless already 2^CW-1, in which case it SHALL hold (no wrap); Match still pulses.
REQ-022 Sat SHALL be 1 exactly when Pcount is 2^CW-1, updated on the same edge as Pcount.
REQ-023 With OVERLAP=1, the FSM SHALL remain ARMED after a match.
REQ-024 With OVERLAP=0, a match edge SHALL force the FSM to FILL with fill count 0, so the next match requires PW new accepted bits; window contents need not be cleared.
REQ-025 Clear=1 SHALL, on that edge, zero window, fill count, Pcount, Match and Sat, and enter FILL, overriding any simultaneous En/match.
REQ-026 En=0 cycles SHALL not alter the fill count, the FSM state or the counter, and SHALL drive Match to 0.

Reset
REQ-027 nReset=0 SHALL asynchronously force window=0, fill count=0, FSM=FILL, Match=0, Pcount=0, Sat=0, independent of Clk.
REQ-028 Reset asserted mid-stream SHALL discard all partially received bits; after release, the first match requires PW new accepted bits.
REQ-029 Reset deassertion timing is the integrator's responsibility; the block SHALL not synchronise nReset internally.

Verification (PW=4, CW=4 unless stated)
REQ-030 Pattern=1011, Mask=1111, OVERLAP=1, En=1, Sin stream 1,0,1,1,0,1,1 after reset -> Match pulses after the 4th and 7th bits, Pcount=2.
REQ-031 Same stream with OVERLAP=0 -> single Match after the 4th bit, Pcount=1.
REQ-032 Pattern=1011, Sin=1,0,1,1 with En low for 3 cycles between bits 2 and 3 -> one Match one cycle after bit 4 is accepted, none during the gaps.
REQ-033 Mask=0000, 3 bits after reset -> Match=0; 4th and 5th bits -> Match pulses, Pcount=2.
REQ-034 Force 16 matches (all-ones stream, Pattern=1111) -> Pcount stops at 15, Sat=1, Match keeps pulsing; Clear pulse -> Pcount=0, Sat=0, FSM=FILL.
REQ-035 nReset pulsed low between Clk edges after 2 bits -> outputs zero immediately; next Match requires 4 fresh matching bits.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: masked serial pattern matcher with saturating match counter
module seq_pattern_detector #(
  parameter int PW = 8,
  parameter int CW = 16,
  parameter int OVERLAP = 1
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic          En,
  input  logic          Sin,
  input  logic [PW-1:0] Pattern,
  input  logic [PW-1:0] Mask,
  input  logic          Clear,
  output logic          Match,
  output logic [CW-1:0] Pcount,
  output logic          Sat
);
  localparam int FW = $clog2(PW + 1);
  typedef enum logic {FILL, ARMED} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] window, post;
  logic [FW-1:0] fill_cnt, fill_nxt;
  logic last_fill, full, hit, restart;
  logic [CW-1:0] pcount_nxt;
  assign post = {window[PW-2:0], Sin};
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) state <= FILL;
    else state <= state_nxt;
  always_comb
    state_nxt = (Clear || restart) ? FILL : (En && last_fill) ? ARMED : state;
  // The edge accepting the PW-th bit already sees a full post-shift window
  always_comb begin
    last_fill  = (state == FILL) && (fill_cnt == FW'(PW - 1));
    full       = (state == ARMED) || last_fill;
    hit        = En && full && (((post ^ Pattern) & Mask) == '0);
    restart    = hit && (OVERLAP == 0);
    fill_nxt   = (Clear || restart || (En && last_fill)) ? '0 :
                 (En && state == FILL) ? fill_cnt + 1'b1 : fill_cnt;
    pcount_nxt = (hit && !(&Pcount)) ? Pcount + 1'b1 : Pcount;
  end
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      window   <= '0;
      fill_cnt <= '0;
      Match    <= 1'b0;
      Pcount   <= '0;
      Sat      <= 1'b0;
    end else if (Clear) begin
      window   <= '0;
      fill_cnt <= '0;
      Match    <= 1'b0;
      Pcount   <= '0;
      Sat      <= 1'b0;
    end else begin
      window   <= En ? post : window;
      fill_cnt <= fill_nxt;
      Match    <= hit;
      Pcount   <= pcount_nxt;
      Sat      <= &pcount_nxt;
    end
endmodule
